// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a byte, computes parity and paces START/DATA/PARITY/STOP on baud_tick.
// Define UART_TX_PARITY_EN to include the PARITY state; otherwise DATA goes straight to STOP.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [1:0]            select_bit,
    output logic                  data_bit,
    output logic                  parity_bit,
    output logic                  start_bit,
    output logic                  stop_bit,
    output logic                  busy,
    output logic                  tx_done,
    output logic [2:0]            dbg_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_select;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_pending_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [1:0]            w_select_nxt;
    logic                  w_accept;

    // busy is high from acceptance until STOP completes, so an accepted request can never collide with a frame.
    assign w_accept = tx_start && !r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '1;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_select  <= SEL_STOP;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_select  <= w_select_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        if (w_accept) begin
            w_shift_nxt   = tx_data;
            w_pending_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
        end

        // pending is registered, so a tick coinciding with tx_start cannot open the frame early.
        case (r_state)
            S_IDLE: begin
                if (r_pending && baud_tick) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_state_nxt   = S_DATA;
                    w_cnt_nxt     = '0;
                    w_pending_nxt = 1'b0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    w_shift_nxt = {1'b1, r_shift[DATA_WIDTH-1:1]};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (w_state_nxt)
            S_START:  w_select_nxt = SEL_START;
            S_DATA:   w_select_nxt = SEL_DATA;
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_select_nxt = SEL_PARITY;
`endif
            default:  w_select_nxt = SEL_STOP;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= (^tx_data) ^ PARITY_ODD;
        end
    end

    assign parity_bit = r_parity;
`else
    logic [1:0] w_unused_parity;

    assign w_unused_parity = {PARITY_ODD, SEL_PARITY[1]};
    assign parity_bit      = 1'b0;
`endif

    assign select_bit = r_select;
    assign data_bit   = r_shift[0];
    assign start_bit  = 1'b0;
    assign stop_bit   = 1'b1;
    assign busy       = r_busy;
    assign tx_done    = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed vector table plus random frames checked against a slot-queue frame model.
// Two instances share stimulus so even and odd parity are checked on every frame.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int N_SLOTS = PAR_EN ? W + 3 : W + 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         baud_tick = 1'b0;
    logic         tx_start  = 1'b0;
    logic [W-1:0] tx_data   = '0;

    logic [1:0] sel_e, sel_o;
    logic       data_e, data_o, par_e, par_o, sb_e, sb_o, pb_e, pb_o;
    logic       busy_e, busy_o, done_e, done_o;
    logic [2:0] dbg_e, dbg_o;

    uart_tx_ctrl #(.DATA_WIDTH(W), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(tx_start), .tx_data(tx_data),
        .select_bit(sel_e), .data_bit(data_e), .parity_bit(par_e), .start_bit(sb_e),
        .stop_bit(pb_e), .busy(busy_e), .tx_done(done_e), .dbg_state(dbg_e)
    );

    uart_tx_ctrl #(.DATA_WIDTH(W), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(tx_start), .tx_data(tx_data),
        .select_bit(sel_o), .data_bit(data_o), .parity_bit(par_o), .start_bit(sb_o),
        .stop_bit(pb_o), .busy(busy_o), .tx_done(done_o), .dbg_state(dbg_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_done_e = 0;
    int cnt_done_o = 0;

    // expected frame: one {select, data} entry per tick interval
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (done_e) cnt_done_e++;
        if (done_o) cnt_done_o++;
    endtask

    function automatic logic model_parity(input logic [W-1:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        return PAR_EN ? logic'((ones % 2) ^ int'(odd)) : 1'b0;
    endfunction

    task automatic build_frame(input logic [W-1:0] d);
        exp_q.delete();
        exp_q.push_back(3'b000);
        for (int i = 0; i < W; i++) exp_q.push_back({2'b01, d[i]});
        if (PAR_EN) exp_q.push_back(3'b100);
        exp_q.push_back(3'b110);
    endtask

    // driver: accept d, then tick every 'period' clocks until tx_done or the tick budget runs out
    task automatic run_frame(input string tag, input logic [W-1:0] d, input int period,
                             input bit with_tick, input int inj_tick, input logic exp_pe,
                             input logic exp_po, input bit b2b);
        logic [2:0] slot;
        int ticks;
        bit seen_done;
        build_frame(d);
        cnt_done_e = 0;
        cnt_done_o = 0;
        tx_data   = d;
        tx_start  = 1'b1;
        baud_tick = with_tick;
        step();
        tx_start  = 1'b0;
        baud_tick = 1'b0;
        tx_data   = W'($urandom);
        chk({tag, "/busy_acc"}, 32'(busy_e), 32'd1);
        chk({tag, "/sel_acc"}, 32'(sel_e), 32'h3);
        chk({tag, "/par_even"}, 32'(par_e), 32'(exp_pe));
        chk({tag, "/par_odd"}, 32'(par_o), 32'(exp_po));
        ticks = 0;
        seen_done = 1'b0;
        while (!seen_done && ticks < N_SLOTS + 4) begin
            repeat (period - 1) step();
            baud_tick = 1'b1;
            if (ticks + 1 == inj_tick) begin
                tx_start = 1'b1;
                tx_data  = 8'h3C;
            end
            step();
            baud_tick = 1'b0;
            tx_start  = 1'b0;
            ticks++;
            if (done_e) begin
                seen_done = 1'b1;
            end else begin
                slot = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b111;
                chk({tag, "/sel"}, 32'(sel_e), 32'(slot[2:1]));
                chk({tag, "/busy"}, 32'(busy_e), 32'd1);
                if (slot[2:1] == 2'b01) chk({tag, "/data"}, 32'(data_e), 32'(slot[0]));
            end
        end
        chk({tag, "/done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "/intervals"}, 32'(ticks - 1), 32'(N_SLOTS));
        chk({tag, "/busy_end"}, 32'(busy_e), 32'd0);
        chk({tag, "/sel_end"}, 32'(sel_e), 32'h3);
        chk({tag, "/done_cnt_e"}, 32'(cnt_done_e), 32'd1);
        chk({tag, "/done_cnt_o"}, 32'(cnt_done_o), 32'd1);
        if (!b2b) begin
            step();
            chk({tag, "/done_pulse"}, 32'(done_e), 32'd0);
        end
    endtask

    // after a frame: ticks must not start anything new
    task automatic idle_ticks(input string tag, input int n, input int period);
        for (int k = 0; k < n; k++) begin
            repeat (period - 1) step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            chk({tag, "/idle_busy"}, 32'(busy_e), 32'd0);
            chk({tag, "/idle_sel"}, 32'(sel_e), 32'h3);
            chk({tag, "/idle_done"}, 32'(done_e), 32'd0);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           period;
        bit           with_tick;
        int           inj;
        logic         pe;
        logic         po;
        bit           b2b;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] rd;
        int rp;
        bit rt;

        vecs[0] = '{8'hA5, 4, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 3, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 2, 1'b0, 6, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 3, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h6E, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0};

        repeat (3) step();
        rst = 1'b0;
        chk("rst/sel", 32'(sel_e), 32'h3);
        chk("rst/data", 32'(data_e), 32'd1);
        chk("rst/par_e", 32'(par_e), 32'd0);
        chk("rst/par_o", 32'(par_o), 32'd0);
        chk("rst/busy", 32'(busy_e), 32'd0);
        chk("rst/done", 32'(done_e), 32'd0);
        chk("rst/start_bit", 32'(sb_e), 32'd0);
        chk("rst/stop_bit", 32'(pb_e), 32'd1);

        for (int v = 0; v < 7; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].period, vecs[v].with_tick,
                      vecs[v].inj, PAR_EN ? vecs[v].pe : 1'b0, PAR_EN ? vecs[v].po : 1'b0,
                      vecs[v].b2b);
            if (!vecs[v].b2b) idle_ticks($sformatf("vec%0d", v), 2, vecs[v].period);
        end

        // reset during DATA bit 4 of 0xFF
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
        end
        chk("abort/in_data", 32'(sel_e), 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort/sel", 32'(sel_e), 32'h3);
        chk("abort/data", 32'(data_e), 32'd1);
        chk("abort/busy", 32'(busy_e), 32'd0);
        chk("abort/done", 32'(done_e), 32'd0);
        idle_ticks("abort", 3, 2);
        run_frame("after_abort", 8'h81, 2, 1'b0, 0, model_parity(8'h81, 1'b0),
                  model_parity(8'h81, 1'b1), 1'b0);

        // random frames against the model
        for (int r = 0; r < 25; r++) begin
            rd = W'($urandom);
            rp = $urandom_range(1, 5);
            rt = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
            run_frame($sformatf("rnd%0d", r), rd, rp, rt, 0, model_parity(rd, 1'b0),
                      model_parity(rd, 1'b1), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
